// File: rtl/mem_responder.sv
// Byte-wide RAM plus memory-mapped IO (TX FIFO, halt flag, optional RX holding register).
// Define MEM_RESPONDER_RX_EN to build the RX holding register; without it RX is tied off.
module mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        halt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_CTRL = 18'h30004;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_IO_RD_DATA,
        ACC_IO_RD_STAT,
        ACC_IO_WR_DATA,
        ACC_IO_WR_CTRL,
        ACC_IO_OTHER
    } acc_t;

    acc_t                  acc;
    logic                  io_sel;
    logic [17:0]           io_addr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  unused_mem_a;

    assign io_addr      = mem_a[17:0];
    assign ram_addr     = mem_a[ADDR_WIDTH-1:0];
    assign io_sel       = (mem_a[17:16] == 2'b11);
    assign unused_mem_a = ^mem_a[31:18];

    always_comb begin
        acc = ACC_NONE;
        if (rdy_in) begin
            if (!io_sel)
                acc = mem_wr ? ACC_RAM_WR : ACC_RAM_RD;
            else if (io_addr == IO_DATA)
                acc = mem_wr ? ACC_IO_WR_DATA : ACC_IO_RD_DATA;
            else if (io_addr == IO_CTRL)
                acc = mem_wr ? ACC_IO_WR_CTRL : ACC_IO_RD_STAT;
            else
                acc = ACC_IO_OTHER;
        end
    end

    // ------------------------------------------------------------------
    // RAM: no reset so contents survive rst_in; read port is registered.
    // ------------------------------------------------------------------
    logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (acc == ACC_RAM_WR)
            ram[ram_addr] <= mem_dout;
        if (acc == ACC_RAM_RD)
            ram_q <= ram[ram_addr];
    end

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    logic       rx_full;
    logic [7:0] rx_buf;

`ifdef MEM_RESPONDER_RX_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_full <= 1'b0;
            rx_buf  <= '0;
        end else if (rx_valid && !rx_full) begin
            rx_buf  <= rx_data;
            rx_full <= 1'b1;
        end else if (acc == ACC_IO_RD_DATA && rx_full) begin
            rx_full <= 1'b0;
        end
    end

    assign rx_ready = !rx_full;
`else
    logic unused_rx;

    assign rx_full   = 1'b0;
    assign rx_buf    = '0;
    assign rx_ready  = 1'b0;
    assign unused_rx = ^{rx_data, rx_valid};
`endif

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tx_push;
    logic             tx_pop;

    // Push is gated on the current full state, so a same-cycle pop never rescues it.
    assign tx_push        = (acc == ACC_IO_WR_DATA) && !io_buffer_full;
    assign tx_pop         = tx_valid && tx_ready;
    assign tx_valid       = (count != '0);
    assign io_buffer_full = (count == CNT_W'(FIFO_DEPTH));
    assign tx_data        = tx_mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (tx_push)
            tx_mem[wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (tx_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-data path and halt flag
    // ------------------------------------------------------------------
    logic       rd_src_ram;
    logic [7:0] io_q;

    // mem_din is a mux of two registers; reset clears the select and io_q,
    // forcing 0x00 immediately while leaving the RAM read register untouched.
    assign mem_din = rd_src_ram ? ram_q : io_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_src_ram <= 1'b0;
            io_q       <= '0;
            halt       <= 1'b0;
        end else begin
            if (acc != ACC_NONE) begin
                rd_src_ram <= (acc == ACC_RAM_RD);
                case (acc)
                    ACC_IO_RD_DATA: io_q <= rx_full ? rx_buf : 8'h00;
                    ACC_IO_RD_STAT: io_q <= {6'b0, rx_full, io_buffer_full};
                    default:        io_q <= '0;
                endcase
            end
            if (acc == ACC_IO_WR_CTRL)
                halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; RX checks follow MEM_RESPONDER_RX_EN.
module tb_mem_responder;

`ifdef MEM_RESPONDER_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        halt;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    mem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .halt          (halt),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        rdy_in   = 1'b1;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        tick();
    endtask

    task automatic idle();
        rdy_in = 1'b0;
        mem_wr = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b0;
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tick();
        tick();
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_halt", halt, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_full", io_buffer_full, 1'b0);
        check("rst_rx_ready", rx_ready, RX_EN);
        rst_in = 1'b0;
        tick();

        // Single write/read
        bus(32'h00010, 1'b1, 8'hA5);
        check("wr_mem_din_zero", mem_din, 8'h00);
        bus(32'h00010, 1'b0, 8'h00);
        check("rd_a5", mem_din, 8'hA5);
        bus(32'h00020, 1'b1, 8'h3C);
        check("wr_after_rd_zero", mem_din, 8'h00);

        // Back-to-back reads
        bus(32'h00000, 1'b1, 8'h11);
        bus(32'h00001, 1'b1, 8'h22);
        bus(32'h00002, 1'b1, 8'h33);
        bus(32'h00003, 1'b1, 8'h44);
        bus(32'h00000, 1'b0, 8'h00);
        check("b2b_0", mem_din, 8'h11);
        bus(32'h00001, 1'b0, 8'h00);
        check("b2b_1", mem_din, 8'h22);
        bus(32'h00002, 1'b0, 8'h00);
        check("b2b_2", mem_din, 8'h33);
        bus(32'h00003, 1'b0, 8'h00);
        check("b2b_3", mem_din, 8'h44);

        // Top RAM byte
        bus(32'h1FFFF, 1'b1, 8'h7E);
        bus(32'h1FFFF, 1'b0, 8'h00);
        check("ram_top", mem_din, 8'h7E);
        idle();

        // TX fill past full with sink stalled
        for (int k = 1; k <= 9; k++) begin
            bus(32'h30000, 1'b1, 8'(k));
            check("fill_full", io_buffer_full, (k >= 8) ? 1 : 0);
            check("fill_valid", tx_valid, 1'b1);
        end
        bus(32'h30004, 1'b0, 8'h00);
        check("status_full", mem_din, RX_EN ? 8'h01 : 8'h01);
        idle();
        tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_valid", tx_valid, 1'b1);
            check("drain_data", tx_data, k);
            tick();
        end
        check("drain_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Full FIFO: push dropped even with a same-cycle pop
        for (int k = 0; k < 8; k++)
            bus(32'h30000, 1'b1, 8'(8'h10 + k));
        check("refill_full", io_buffer_full, 1'b1);
        tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'h99);
        idle();
        check("drop_pop_full", io_buffer_full, 1'b0);
        for (int k = 1; k < 8; k++) begin
            check("drop_pop_data", tx_data, 8'h10 + k);
            tick();
        end
        check("drop_pop_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Simultaneous push/pop on a one-entry FIFO
        bus(32'h30000, 1'b1, 8'hAA);
        tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'hBB);
        idle();
        check("pp_valid", tx_valid, 1'b1);
        check("pp_data", tx_data, 8'hBB);
        tick();
        check("pp_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Unmapped IO address
        bus(32'h00010, 1'b0, 8'h00);
        bus(32'h30008, 1'b0, 8'h00);
        check("io_other_rd", mem_din, 8'h00);
        bus(32'h30008, 1'b1, 8'h55);
        idle();
        check("io_other_wr_nopush", tx_valid, 1'b0);
        check("io_other_wr_nohalt", halt, 1'b0);

        // RX path
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'hC3;
        check("rx_ready_full", rx_ready, 1'b0);
        bus(32'h30004, 1'b0, 8'h00);
        check("rx_status", mem_din, RX_EN ? 8'h02 : 8'h00);
        bus(32'h30000, 1'b0, 8'h00);
        check("rx_read", mem_din, RX_EN ? 8'h5A : 8'h00);
        idle();
        check("rx_ready_after", rx_ready, RX_EN);
        bus(32'h30000, 1'b0, 8'h00);
        check("rx_read_empty", mem_din, 8'h00);

        // Halt and rdy_in freeze
        bus(32'h30004, 1'b1, 8'h01);
        check("halt_set", halt, 1'b1);
        bus(32'h00001, 1'b0, 8'h00);
        rdy_in   = 1'b0;
        mem_a    = 32'h00010;
        mem_wr   = 1'b1;
        mem_dout = 8'hFF;
        tick();
        tick();
        check("frozen_mem_din", mem_din, 8'h22);
        bus(32'h00010, 1'b0, 8'h00);
        check("frozen_ram", mem_din, 8'hA5);
        bus(32'h00001, 1'b0, 8'h00);
        check("pre_rst_mem_din", mem_din, 8'h22);

        // Asynchronous reset in mid-cycle with a push pending
        bus(32'h30000, 1'b1, 8'h61);
        check("pre_rst_valid", tx_valid, 1'b1);
        rdy_in   = 1'b1;
        mem_a    = 32'h30000;
        mem_wr   = 1'b1;
        mem_dout = 8'h77;
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_mem_din", mem_din, 8'h00);
        check("arst_halt", halt, 1'b0);
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_full", io_buffer_full, 1'b0);
        check("arst_rx_ready", rx_ready, RX_EN);
        tick();
        idle();
        rst_in = 1'b0;
        tick();
        check("post_rst_tx_valid", tx_valid, 1'b0);
        bus(32'h00010, 1'b0, 8'h00);
        check("post_rst_ram_10", mem_din, 8'hA5);
        bus(32'h00003, 1'b0, 8'h00);
        check("post_rst_ram_3", mem_din, 8'h44);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
